// File: rtl/jtvigil_colmix_if.sv
// CPU-side palette bus between the main CPU decoder and jtvigil_colmix.
interface jtvigil_colmix_if;
   logic [9:0] main_addr;
   logic [7:0] main_dout;
   logic       main_rnw;
   logic       pal_cs;
   logic [7:0] main_din;

   modport master (output main_addr, main_dout, main_rnw, pal_cs, input main_din);
   modport slave  (input main_addr, main_dout, main_rnw, pal_cs, output main_din);
endinterface

// File: rtl/jtvigil_colmix.sv
// Vigilante colour mixer: layer priority, RGB palette lookup, blank gating.
// Optional macro JTVIGIL_COLMIX_DBG_EN: debug_bus[3] shows index[7:3] as grey.
module jtvigil_colmix #(
   parameter int BLANK_DLY = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pxl_cen,
   input  logic             LHBL,
   input  logic             LVBL,
   input  logic [7:0]       scr1_pxl,
   input  logic [3:0]       scr2_pxl,
   input  logic [5:0]       obj_pxl,
   jtvigil_colmix_if.slave  bus,
   input  logic [3:0]       gfx_en,
   input  logic [3:0]       debug_bus,
   output logic [4:0]       red,
   output logic [4:0]       green,
   output logic [4:0]       blue,
   output logic             LHBL_dly,
   output logic             LVBL_dly
);

   logic                 s1t, obt;
   logic [7:0]           idx_next, idx_reg;
   logic [BLANK_DLY-1:0] hb_sr_reg, vb_sr_reg;
   logic                 blank_ok;
   logic [1:0]           cpu_sel;
   logic [7:0]           cpu_entry;
   logic [4:0]           cpu_rd [0:2];
   logic [4:0]           col_reg [0:2];
   logic [7:0]           cpu_word;

   assign cpu_sel   = bus.main_addr[9:8];
   assign cpu_entry = bus.main_addr[7:0];

   always_comb begin
      s1t      = (scr1_pxl[3:0] == 4'd0) || !gfx_en[0];
      obt      = (obj_pxl[3:0] == 4'd0) || !gfx_en[3];
      idx_next = 8'hC0;
      if (!s1t && (scr1_pxl[7] || obt))
         idx_next = {1'b0, scr1_pxl[6:0]};
      else if (!obt)
         idx_next = {2'b10, obj_pxl};
      else if (gfx_en[1])
         idx_next = {4'b1100, scr2_pxl};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg   <= 8'h00;
         hb_sr_reg <= '0;
         vb_sr_reg <= '0;
      end else if (pxl_cen) begin
         idx_reg   <= idx_next;
         hb_sr_reg <= (hb_sr_reg << 1) | BLANK_DLY'(LHBL);
         vb_sr_reg <= (vb_sr_reg << 1) | BLANK_DLY'(LVBL);
      end
   end

   assign LHBL_dly = hb_sr_reg[BLANK_DLY-1];
   assign LVBL_dly = vb_sr_reg[BLANK_DLY-1];

   // Gate with the blank tap that becomes *_dly on the same edge as the RGB update
   generate
      if (BLANK_DLY > 1) begin : g_gate_sr
         assign blank_ok = hb_sr_reg[BLANK_DLY-2] & vb_sr_reg[BLANK_DLY-2];
      end else begin : g_gate_in
         assign blank_ok = LHBL & LVBL;
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_pal
         logic [4:0] mem [0:255];
         logic [4:0] pix_col;

         always_ff @(posedge clk) begin
            if (bus.pal_cs && !bus.main_rnw && cpu_sel == 2'(gi))
               mem[cpu_entry] <= bus.main_dout[4:0];
         end

         assign cpu_rd[gi] = mem[cpu_entry];

`ifdef JTVIGIL_COLMIX_DBG_EN
         always_comb begin
            pix_col = mem[idx_reg];
            if (debug_bus[3])
               pix_col = idx_reg[7:3];
         end
`else
         always_comb begin
            pix_col = mem[idx_reg];
         end
`endif

         // Same-clk CPU write to this entry is not seen here until the next pxl_cen
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               col_reg[gi] <= 5'd0;
            else if (pxl_cen)
               col_reg[gi] <= blank_ok ? pix_col : 5'd0;
         end
      end
   endgenerate

   always_comb begin
      cpu_word = 8'h00;
      case (cpu_sel)
         2'd0:    cpu_word = {3'b000, cpu_rd[0]};
         2'd1:    cpu_word = {3'b000, cpu_rd[1]};
         2'd2:    cpu_word = {3'b000, cpu_rd[2]};
         default: cpu_word = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bus.main_din <= 8'h00;
      else
         bus.main_din <= cpu_word;
   end

   assign red   = col_reg[0];
   assign green = col_reg[1];
   assign blue  = col_reg[2];

`ifdef JTVIGIL_COLMIX_DBG_EN
   logic unused_bits;
   assign unused_bits = ^{debug_bus[2:0], gfx_en[2], bus.main_dout[7:5]};
`else
   logic unused_bits;
   assign unused_bits = ^{debug_bus, gfx_en[2], bus.main_dout[7:5]};
`endif

endmodule

// File: doc/jtvigil_colmix.md
Name: jtvigil_colmix

Overview:
- Colour mixer / palette stage directly downstream of the Vigilante video block.
- Takes the per-pixel layer outputs and resolves priority and transparency between them:
  - scroll layer 1 (scr1) pixel
  - scroll layer 2 (scr2) pixel
  - sprite (obj) pixel
- Looks the winning index up in CPU-writable palette RAM.
- Emits blank-gated 5-bit RGB with matching delayed blanking signals to the frame output.

Parameters:
- BLANK_DLY, 2, pxl_cen cycles of delay applied to LHBL/LVBL. Must equal the pixel pipeline latency.

Ports:
- clk  in  1  system clock, 48 MHz
- rst_n  in  1  asynchronous reset, active low
- pxl_cen  in  1  pixel clock enable, 6 MHz
- LHBL  in  1  horizontal blank, active low, from the video timer
- LVBL  in  1  vertical blank, active low, from the video timer
- scr1_pxl  in  8  bit 7 = priority over obj; [6:4] = colour; [3:0] = pixel
- scr2_pxl  in  4  background pixel, always opaque
- obj_pxl  in  6  [5:4] = colour; [3:0] = pixel
- main_addr  in  10  CPU palette address
- main_dout  in  8  CPU write data
- main_rnw  in  1  1 = read, 0 = write
- pal_cs  in  1  palette chip select
- main_din  out  8  CPU read data
- gfx_en  in  4  layer enables: [0] = scr1, [1] = scr2, [3] = obj
- debug_bus  in  4  debug control; used only with the optional feature
- red  out  5  red component
- green  out  5  green component
- blue  out  5  blue component
- LHBL_dly  out  1  LHBL delayed by BLANK_DLY pixels
- LVBL_dly  out  1  LVBL delayed by BLANK_DLY pixels

Behaviour:
- Clocking and reset:
  - Single clock, clk. Reset rst_n is asynchronous and active low.
  - All registers clear on reset: red, green, blue, main_din, LHBL_dly, LVBL_dly, and the internal index register are all 0.
  - Palette RAM contents are not cleared by reset.
- Palette organisation:
  - Three 256x5 dual-port RAMs: R, G and B.
  - CPU address: main_addr[9:8] selects the component (0 = R, 1 = G, 2 = B, 3 = unmapped); main_addr[7:0] is the entry.
- CPU access, on clk and independent of pxl_cen:
  - Write when pal_cs=1 and main_rnw=0: stores main_dout[4:0] into the selected component. Component 3 ignores writes.
  - main_din is registered every cycle with {3'b0, entry} of the addressed component. Component 3 reads 8'h00.
  - Read data is valid 1 clk after the address.
- Stage 1, on pxl_cen: priority and transparency.
  - s1t (scr1 transparent) = (scr1_pxl[3:0]==0) or !gfx_en[0].
  - obt (obj transparent) = (obj_pxl[3:0]==0) or !gfx_en[3].
  - Selected index, in priority order:
    - if !s1t and (scr1_pxl[7] or obt): index = {1'b0, scr1_pxl[6:0]}
    - else if !obt: index = {2'b10, obj_pxl}
    - else if gfx_en[1]: index = {4'b1100, scr2_pxl}
    - else: index = 8'hC0
- Stage 2, on pxl_cen:
  - The three RAMs are read at the registered index.
  - Output: red/green/blue = RAM data when both delayed blanks are high, else 0.
- Latency:
  - Layer inputs to RGB: 2 pxl_cen edges.
  - LHBL_dly/LVBL_dly use a BLANK_DLY-deep shift register clocked on pxl_cen, so blanking stays aligned with the RGB it gates.
- Write/read collision: a CPU write and a video read of the same entry in the same clk returns the old value to video. The new value is visible from the next pxl_cen.
- Outputs hold their values between pxl_cen pulses.
- Reset asserted mid-line: outputs go to 0 immediately. The first valid pixel appears 2 pxl_cen after release.

Optional Feature:
- Macro: JTVIGIL_COLMIX_DBG_EN.
- When defined and debug_bus[3]=1:
  - The palette lookup is bypassed.
  - red = green = blue = stage-1 index[7:3], so each layer's index region shows as a grey band.
  - Blank gating still applies.
- When debug_bus[3]=0, or when the macro is undefined, behaviour is normal. Without the macro, debug_bus is unused and no bypass logic is synthesised.

Test Plan:
- Reset value: assert rst_n=0 while pxl_cen toggles -> red, green, blue, main_din, LHBL_dly and LVBL_dly are all 0. After release with LHBL=LVBL=1, LHBL_dly rises on the 2nd pxl_cen.
- CPU palette access:
  - Write addr 0x005 = 0x1F, 0x105 = 0x0A, 0x205 = 0x03; then read 0x105 -> main_din = 0x0A one clk later.
  - Write then read 0x305 -> main_din = 0x00.
- Priority:
  - scr1_pxl = 0x05, obj_pxl = 0x21 -> index 0xA1 (obj wins).
  - scr1_pxl = 0x85, same obj -> index 0x05; RGB = (0x1F, 0x0A, 0x03) after 2 pxl_cen.
- Transparency:
  - scr1_pxl = 0x70, obj_pxl = 0x30, scr2_pxl = 0x7 -> index 0xC7.
  - Same inputs with gfx_en[1]=0 -> index 0xC0.
- Blanking: LHBL=0 with an opaque pixel -> RGB = 0 exactly 2 pxl_cen later, aligned with LHBL_dly=0.
- Collision: CPU write to entry 0x05 in the same clk as the video read of 0x05 -> old colour output. The next pixel at 0x05 shows the new colour.
